// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the memory controller slice:
//   - memory visit codes driven on mem_vis_signal (IDLE/WRITE/READ_DATA/READ_INST)
//   - data_size codes (BYTE/HALF/WORD; code 3 is treated as WORD)
//   - controller state encoding IDLE/ACCESS/TAIL/DONE
//   - helpers: size code -> byte count, alignment test used when
//     MEM_CTRL_MISALIGN_CHECK_EN is defined
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package mem_ctrl_pkg;

   localparam logic [1:0] VIS_IDLE      = 2'b00;
   localparam logic [1:0] VIS_WRITE     = 2'b01;
   localparam logic [1:0] VIS_READ_DATA = 2'b10;
   localparam logic [1:0] VIS_READ_INST = 2'b11;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_TAIL   = 2'b10,
      ST_DONE   = 2'b11
   } state_t;

   // Number of memory bytes touched by a request of the given size code.
   function automatic logic [2:0] size_to_n(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: size_to_n = 3'd1;
         SZ_HALF: size_to_n = 3'd2;
         default: size_to_n = 3'd4;
      endcase
   endfunction

   // Halfwords need an even address, words a 4-byte aligned one.
   function automatic logic misaligned(input logic [2:0] n, input logic [1:0] a);
      misaligned = ((n == 3'd2) && a[0]) || ((n == 3'd4) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
// Bundles the requester side (icache fetch port, dcache data port) and the
// byte-wide main-memory port of mem_ctrl.
//   slave  : view used by mem_ctrl (takes requests + mem_data, drives the rest)
//   master : view used by the environment (caches + memory model)
// Optional macro MEM_CTRL_MISALIGN_CHECK_EN adds data_err.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface mem_ctrl_if #(
   parameter int ADDR_WIDTH = 20,
   parameter int LEN        = 32,
   parameter int BYTE_SIZE  = 8
) ();
   logic                  inst_req;
   logic [ADDR_WIDTH-1:0] inst_addr;
   logic                  inst_done;
   logic [LEN-1:0]        inst_data;
   logic                  data_req;
   logic                  data_we;
   logic [1:0]            data_size;
   logic [ADDR_WIDTH-1:0] data_addr;
   logic [LEN-1:0]        data_wdata;
   logic                  data_done;
   logic [LEN-1:0]        data_rdata;
   logic                  busy;
   logic [1:0]            mem_vis_signal;
   logic [ADDR_WIDTH-1:0] mem_vis_addr;
   logic [BYTE_SIZE-1:0]  writen_data;
   logic [BYTE_SIZE-1:0]  mem_data;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
   logic                  data_err;
`endif

   modport slave (
      input  inst_req, inst_addr, data_req, data_we, data_size, data_addr,
             data_wdata, mem_data,
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
      output data_err,
`endif
      output inst_done, inst_data, data_done, data_rdata, busy,
             mem_vis_signal, mem_vis_addr, writen_data
   );

   modport master (
      output inst_req, inst_addr, data_req, data_we, data_size, data_addr,
             data_wdata, mem_data,
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
      input  data_err,
`endif
      input  inst_done, inst_data, data_done, data_rdata, busy,
             mem_vis_signal, mem_vis_addr, writen_data
   );
endinterface

// File: rtl/mem_ctrl_packer.sv
// -----------------------------------------------------------------------------
// mem_byte_packer
// Byte counter plus slicing/assembly for mem_ctrl.
//   clk, rst     : clock, synchronous active-high reset
//   i_load       : request accepted; latch i_wdata, clear counter and result
//   i_wdata      : write word presented at accept
//   i_adv        : advance the byte counter (one per ACCESS cycle)
//   i_cap        : store i_mem_data into result byte (o_cnt-1)
//   i_mem_data   : read byte from memory
//   o_cnt        : current byte counter
//   o_next_byte  : write byte for the following ACCESS cycle (index o_cnt+1)
//   o_merged     : result with i_mem_data inserted at byte (o_cnt-1)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_byte_packer #(
   parameter int LEN       = 32,
   parameter int BYTE_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_load,
   input  logic [LEN-1:0]       i_wdata,
   input  logic                 i_adv,
   input  logic                 i_cap,
   input  logic [BYTE_SIZE-1:0] i_mem_data,
   output logic [2:0]           o_cnt,
   output logic [BYTE_SIZE-1:0] o_next_byte,
   output logic [LEN-1:0]       o_merged
);
   logic [2:0]     r_cnt;
   logic [LEN-1:0] r_wdata;
   logic [LEN-1:0] r_result;
   logic [1:0]     w_cap_idx;
   logic [1:0]     w_next_idx;
   logic [LEN-1:0] w_merged;

   // Memory returns a byte one cycle after its address, so the byte landing
   // now belongs to the previous counter value.
   assign w_cap_idx  = 2'(r_cnt - 3'd1);
   assign w_next_idx = 2'(r_cnt + 3'd1);

   always_comb begin
      w_merged = r_result;
      w_merged[w_cap_idx*BYTE_SIZE +: BYTE_SIZE] = i_mem_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= 3'd0;
         r_wdata  <= '0;
         r_result <= '0;
      end else if (i_load) begin
         r_cnt    <= 3'd0;
         r_wdata  <= i_wdata;
         r_result <= '0;
      end else begin
         if (i_adv) r_cnt <= r_cnt + 3'd1;
         if (i_cap) r_result <= w_merged;
      end
   end

   assign o_cnt       = r_cnt;
   assign o_next_byte = r_wdata[w_next_idx*BYTE_SIZE +: BYTE_SIZE];
   assign o_merged    = w_merged;
endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Arbitrates the byte-wide main memory between instruction fetch and data
// requests (data has fixed priority) and serialises each word/halfword/byte
// request into little-endian byte accesses. All outputs are registered.
//   clk  : clock
//   rst  : synchronous active-high reset (aborts any transfer, no done pulse)
//   bus  : mem_ctrl_if.slave -- requester ports, done/data returns, busy and
//          the memory port (mem_vis_signal, mem_vis_addr, writen_data, mem_data)
// Optional macro MEM_CTRL_MISALIGN_CHECK_EN: misaligned requests skip memory
// and complete in one cycle; data requests additionally pulse data_err.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 20,
   parameter int LEN        = 32,
   parameter int BYTE_SIZE  = 8
) (
   input logic        clk,
   input logic        rst,
   mem_ctrl_if.slave  bus
);
   state_t                r_state, w_next;
   logic                  r_grant_data, r_we;
   logic [2:0]            r_n;
   logic [1:0]            r_vis, w_vis;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr;
   logic [BYTE_SIZE-1:0]  r_wbyte, w_wbyte;
   logic                  r_inst_done, w_inst_done, r_data_done, w_data_done;
   logic [LEN-1:0]        r_inst_data, w_inst_data, r_data_rdata, w_data_rdata;
   logic                  r_busy;
   logic                  w_accept, w_adv, w_cap, w_last;
   logic                  w_sel_data, w_sel_we;
   logic [2:0]            w_sel_n;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [2:0]            w_cnt;
   logic [BYTE_SIZE-1:0]  w_next_byte;
   logic [LEN-1:0]        w_merged;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
   logic                  r_err, w_err, w_sel_mis;
`endif

   mem_byte_packer #(.LEN(LEN), .BYTE_SIZE(BYTE_SIZE)) u_packer (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_accept),
      .i_wdata     (bus.data_wdata),
      .i_adv       (w_adv),
      .i_cap       (w_cap),
      .i_mem_data  (bus.mem_data),
      .o_cnt       (w_cnt),
      .o_next_byte (w_next_byte),
      .o_merged    (w_merged)
   );

   // Request selection: data wins, instruction fetches are always word reads.
   assign w_sel_data = bus.data_req;
   assign w_sel_we   = bus.data_req & bus.data_we;
   assign w_sel_n    = bus.data_req ? size_to_n(bus.data_size) : 3'd4;
   assign w_sel_addr = bus.data_req ? bus.data_addr : bus.inst_addr;
   assign w_last     = (w_cnt == (r_n - 3'd1));
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
   assign w_sel_mis  = misaligned(w_sel_n, w_sel_addr[1:0]);
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next-state and next-output logic; outputs are registered below so each
   // value computed here appears on the bus in the following cycle.
   always_comb begin
      w_next       = r_state;
      w_vis        = VIS_IDLE;
      w_addr       = r_addr;
      w_wbyte      = r_wbyte;
      w_inst_done  = 1'b0;
      w_data_done  = 1'b0;
      w_inst_data  = r_inst_data;
      w_data_rdata = r_data_rdata;
      w_accept     = 1'b0;
      w_adv        = 1'b0;
      w_cap        = 1'b0;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
      w_err        = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (bus.data_req || bus.inst_req) begin
               w_accept = 1'b1;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
               if (w_sel_mis) begin
                  w_next      = ST_DONE;
                  w_data_done = w_sel_data;
                  w_inst_done = ~w_sel_data;
                  w_err       = w_sel_data;
               end else begin
`endif
                  w_next  = ST_ACCESS;
                  w_addr  = w_sel_addr;
                  w_wbyte = bus.data_wdata[BYTE_SIZE-1:0];
                  w_vis   = w_sel_we ? VIS_WRITE :
                            (w_sel_data ? VIS_READ_DATA : VIS_READ_INST);
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
               end
`endif
            end
         end
         ST_ACCESS: begin
            w_adv = 1'b1;
            w_cap = ~r_we && (w_cnt != 3'd0);
            if (w_last) begin
               // Writes finish here; reads wait one cycle for the last byte.
               w_next = r_we ? ST_DONE : ST_TAIL;
               if (r_we) begin
                  w_data_done = r_grant_data;
                  w_inst_done = ~r_grant_data;
               end
            end else begin
               w_vis   = r_vis;
               w_addr  = r_addr + 1'b1;
               w_wbyte = w_next_byte;
            end
         end
         ST_TAIL: begin
            w_cap  = 1'b1;
            w_next = ST_DONE;
            if (r_grant_data) begin
               w_data_done  = 1'b1;
               w_data_rdata = w_merged;
            end else begin
               w_inst_done  = 1'b1;
               w_inst_data  = w_merged;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant_data <= 1'b0;
         r_we         <= 1'b0;
         r_n          <= 3'd0;
         r_vis        <= VIS_IDLE;
         r_addr       <= '0;
         r_wbyte      <= '0;
         r_inst_done  <= 1'b0;
         r_data_done  <= 1'b0;
         r_inst_data  <= '0;
         r_data_rdata <= '0;
         r_busy       <= 1'b0;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
         r_err        <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_grant_data <= w_sel_data;
            r_we         <= w_sel_we;
            r_n          <= w_sel_n;
         end
         r_vis        <= w_vis;
         r_addr       <= w_addr;
         r_wbyte      <= w_wbyte;
         r_inst_done  <= w_inst_done;
         r_data_done  <= w_data_done;
         r_inst_data  <= w_inst_data;
         r_data_rdata <= w_data_rdata;
         r_busy       <= (w_next != ST_IDLE);
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
         r_err        <= w_err;
`endif
      end
   end

   assign bus.mem_vis_signal = r_vis;
   assign bus.mem_vis_addr   = r_addr;
   assign bus.writen_data    = r_wbyte;
   assign bus.inst_done      = r_inst_done;
   assign bus.inst_data      = r_inst_data;
   assign bus.data_done      = r_data_done;
   assign bus.data_rdata     = r_data_rdata;
   assign bus.busy           = r_busy;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
   assign bus.data_err       = r_err;
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
`timescale 1ns/1ps
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   localparam int AW  = 20;
   localparam int LEN = 32;
   localparam int BS  = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_ctrl_if #(.ADDR_WIDTH(AW), .LEN(LEN), .BYTE_SIZE(BS)) bus ();

   mem_ctrl #(.ADDR_WIDTH(AW), .LEN(LEN), .BYTE_SIZE(BS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Byte-wide main memory: writes and read addresses sampled at posedge,
   // read byte presented the following cycle. pl_* is a bench-side preload port.
   logic [7:0]    mem_arr [0:(1<<AW)-1];
   logic          pl_we;
   logic [AW-1:0] pl_addr;
   logic [7:0]    pl_data;

   always @(posedge clk) begin
      if (pl_we) mem_arr[pl_addr] <= pl_data;
      else if (bus.mem_vis_signal == VIS_WRITE) mem_arr[bus.mem_vis_addr] <= bus.writen_data;
      if (bus.mem_vis_signal == VIS_READ_DATA || bus.mem_vis_signal == VIS_READ_INST)
         bus.mem_data <= mem_arr[bus.mem_vis_addr];
   end

   // Reference model: expected memory contents and last returned words.
   bit [7:0]    ref_mem [int];
   logic [31:0] exp_inst_data, exp_data_rdata;
   int          checks, errors;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      tick();
      pl_we = 1'b0;
      ref_mem[int'(a)] = d;
   endtask

   function automatic int nbytes(input bit is_inst, input logic [1:0] sz);
      if (is_inst) return 4;
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit is_mis(input int n, input logic [AW-1:0] a);
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
      return (n == 2 && a % 2 != 0) || (n == 4 && a % 4 != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_read(input logic [AW-1:0] a, input int n);
      logic [31:0] r = 32'h0;
      for (int k = 0; k < n; k++)
         r = r + (32'(ref_mem[int'((32'(a) + k) % (1 << AW))]) << (8 * k));
      return r;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_vis"},   32'(bus.mem_vis_signal), 32'(VIS_IDLE));
      check({tag, "_busy"},  32'(bus.busy), 32'd0);
      check({tag, "_idone"}, 32'(bus.inst_done), 32'd0);
      check({tag, "_ddone"}, 32'(bus.data_done), 32'd0);
      check({tag, "_idata"}, bus.inst_data, 32'd0);
      check({tag, "_rdata"}, bus.data_rdata, 32'd0);
   endtask

   // One complete request, checked cycle by cycle against the spec's timing:
   // byte k issued in cycle A+1+k, done at A+n+2 (reads) / A+n+1 (writes).
   task automatic run_req(input bit is_inst, input bit we, input logic [1:0] sz,
                          input logic [AW-1:0] addr, input logic [31:0] wdata);
      int n, lat, done_at, pulses;
      bit mis;
      logic [1:0]    kind;
      logic [31:0]   exp_r, got, prev;
      logic [AW-1:0] ea;
      logic [7:0]    eb;
      n     = nbytes(is_inst, sz);
      mis   = is_mis(n, addr);
      lat   = mis ? 1 : (we ? n + 1 : n + 2);
      kind  = we ? VIS_WRITE : (is_inst ? VIS_READ_INST : VIS_READ_DATA);
      exp_r = ref_read(addr, n);
      prev  = is_inst ? exp_inst_data : exp_data_rdata;
      got   = 32'hxxxxxxxx;
      done_at = 0; pulses = 0;
      if (is_inst) begin
         bus.inst_addr = addr; bus.inst_req = 1'b1;
      end else begin
         bus.data_addr = addr; bus.data_we = we; bus.data_size = sz;
         bus.data_wdata = wdata; bus.data_req = 1'b1;
      end
      for (int j = 1; j <= lat + 2; j++) begin
         tick();
         check("other_done", 32'(is_inst ? bus.data_done : bus.inst_done), 32'd0);
         if (!mis && j <= n) begin
            ea = addr + AW'(j - 1);
            eb = wdata[8*(j-1) +: 8];
            check("vis", 32'(bus.mem_vis_signal), 32'(kind));
            check("addr", 32'(bus.mem_vis_addr), 32'(ea));
            if (we) check("wbyte", 32'(bus.writen_data), 32'(eb));
         end else begin
            check("vis_idle", 32'(bus.mem_vis_signal), 32'(VIS_IDLE));
         end
         check("busy", 32'(bus.busy), 32'(j <= lat));
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
         check("data_err", 32'(bus.data_err), 32'(j == lat && mis && !is_inst));
`endif
         if (is_inst ? bus.inst_done : bus.data_done) begin
            pulses++;
            if (done_at == 0) begin
               done_at = j;
               got = is_inst ? bus.inst_data : bus.data_rdata;
            end
            bus.inst_req = 1'b0; bus.data_req = 1'b0;
         end
      end
      bus.inst_req = 1'b0; bus.data_req = 1'b0;
      check("done_cycle", 32'(done_at), 32'(lat));
      check("done_pulses", 32'(pulses), 32'd1);
      if (!we && !mis) begin
         check("rdata", got, exp_r);
         if (is_inst) exp_inst_data = exp_r; else exp_data_rdata = exp_r;
      end else begin
         check("rdata_hold_at_done", got, prev);
      end
      if (we && !mis) begin
         for (int k = 0; k < n; k++) begin
            ea = addr + AW'(k);
            ref_mem[int'(ea)] = wdata[8*k +: 8];
            check("mem_byte", 32'(mem_arr[ea]), 32'(wdata[8*k +: 8]));
         end
      end
      check("inst_data_hold", bus.inst_data, exp_inst_data);
      check("data_rdata_hold", bus.data_rdata, exp_data_rdata);
   endtask

   // Simultaneous fetch + data request: data first, fetch right after DONE.
   task automatic run_both(input logic [AW-1:0] iaddr, input logic [AW-1:0] daddr);
      int dj, ij;
      logic [31:0] dgot, igot, dexp, iexp;
      dj = 0; ij = 0;
      dexp = ref_read(daddr, 2);
      iexp = ref_read(iaddr, 4);
      bus.inst_addr = iaddr; bus.inst_req = 1'b1;
      bus.data_addr = daddr; bus.data_we = 1'b0; bus.data_size = SZ_HALF;
      bus.data_req = 1'b1;
      for (int j = 1; j <= 14; j++) begin
         tick();
         if (bus.data_done) begin
            if (dj == 0) begin dj = j; dgot = bus.data_rdata; end
            bus.data_req = 1'b0;
         end
         if (bus.inst_done) begin
            if (ij == 0) begin ij = j; igot = bus.inst_data; end
            bus.inst_req = 1'b0;
         end
      end
      bus.inst_req = 1'b0; bus.data_req = 1'b0;
      check("prio_data_cycle", 32'(dj), 32'd4);
      check("prio_inst_cycle", 32'(ij), 32'd11);
      check("prio_data_rdata", dgot, dexp);
      check("prio_inst_data", igot, iexp);
      exp_data_rdata = dexp;
      exp_inst_data  = iexp;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] a;
      logic [1:0]    sz;
      int            op;
      checks = 0; errors = 0;
      exp_inst_data = 32'h0; exp_data_rdata = 32'h0;
      pl_we = 1'b0; pl_addr = '0; pl_data = '0;
      bus.inst_req = 1'b0; bus.inst_addr = '0;
      bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_size = 2'b00;
      bus.data_addr = '0; bus.data_wdata = '0;
      rst = 1'b1;
      repeat (3) tick();
      check_reset_outputs("reset");
      check("reset_addr", 32'(bus.mem_vis_addr), 32'd0);
      check("reset_wbyte", 32'(bus.writen_data), 32'd0);
      rst = 1'b0;
      tick();

      // Instruction fetch of a preloaded word.
      poke(20'h00100, 8'h13); poke(20'h00101, 8'h05);
      poke(20'h00102, 8'h50); poke(20'h00103, 8'h00);
      run_req(1'b1, 1'b0, SZ_WORD, 20'h00100, 32'h0);
      check("fetch_value", bus.inst_data, 32'h00500513);

      // Word write then byte read inside it.
      run_req(1'b0, 1'b1, SZ_WORD, 20'h00200, 32'hDEADBEEF);
      run_req(1'b0, 1'b0, SZ_BYTE, 20'h00201, 32'h0);
      check("byte_read_value", bus.data_rdata, 32'h000000BE);

      // Fixed priority.
      run_both(20'h00100, 20'h00202);
      check("prio_rdata_value", bus.data_rdata, 32'h0000DEAD);

      // Address wrap at the top of memory.
      run_req(1'b0, 1'b1, SZ_WORD, 20'hFFFFE, 32'hCAFEF00D);
      run_req(1'b0, 1'b0, SZ_WORD, 20'hFFFFE, 32'h0);

      // Reset lands on the edge that would start the second byte of a write.
      poke(20'h00300, 8'h00); poke(20'h00301, 8'h00);
      poke(20'h00302, 8'h00); poke(20'h00303, 8'h00);
      bus.data_addr = 20'h00300; bus.data_we = 1'b1; bus.data_size = SZ_WORD;
      bus.data_wdata = 32'h11223344; bus.data_req = 1'b1;
      tick();
      check("rst_first_vis", 32'(bus.mem_vis_signal), 32'(VIS_WRITE));
      check("rst_first_addr", 32'(bus.mem_vis_addr), 32'h00300);
      rst = 1'b1; bus.data_req = 1'b0;
      tick();
      check_reset_outputs("midrst");
      rst = 1'b0;
      exp_inst_data = 32'h0; exp_data_rdata = 32'h0;
      tick();
      check("midrst_done_later", 32'(bus.data_done), 32'd0);
      check("midrst_mem300", 32'(mem_arr[20'h00300]), 32'h44);
      check("midrst_mem301", 32'(mem_arr[20'h00301]), 32'h00);
      check("midrst_mem302", 32'(mem_arr[20'h00302]), 32'h00);
      check("midrst_mem303", 32'(mem_arr[20'h00303]), 32'h00);
      ref_mem[32'h300] = 8'h44;
      run_req(1'b0, 1'b0, SZ_WORD, 20'h00300, 32'h0);

`ifdef MEM_CTRL_MISALIGN_CHECK_EN
      run_req(1'b0, 1'b0, SZ_WORD, 20'h00302, 32'h0);
      run_req(1'b0, 1'b0, SZ_HALF, 20'h00301, 32'h0);
      run_req(1'b1, 1'b0, SZ_WORD, 20'h00101, 32'h0);
`endif

      // Randomised traffic inside a preloaded window 0x400..0x423.
      for (int w = 0; w < 9; w++)
         run_req(1'b0, 1'b1, SZ_WORD, 20'h00400 + AW'(4 * w), $urandom);
      for (int it = 0; it < 150; it++) begin
         op = int'($urandom_range(0, 2));
         a  = 20'h00400 + AW'($urandom_range(0, 31));
         sz = 2'($urandom_range(0, 3));
         case (op)
            0:       run_req(1'b0, 1'b1, sz, a, $urandom);
            1:       run_req(1'b0, 1'b0, sz, a, 32'h0);
            default: run_req(1'b1, 1'b0, SZ_WORD, a, 32'h0);
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
